// File: rtl/psum_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_arb_pkg
// Description : Shared FSM encoding and round-robin helper for the psum
//               drain arbiter and other column arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_arb_pkg;

    localparam int         c_ST_W     = 1;
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    // Upper bound on requesters the helper can scan.
    localparam int c_MAX_REQ = 32;

    // First set bit of mask searching ptr+1, ptr+2, ... with wrap at n-1.
    // Returns ptr when mask is empty; callers qualify with |mask.
    function automatic int next_rr(input int ptr, input logic [c_MAX_REQ-1:0] mask, input int n);
        int   idx;
        int   win;
        logic found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < c_MAX_REQ; k++) begin
            if (k < n) begin
                idx = (idx == n - 1) ? 0 : idx + 1;
                if (!found && mask[idx[4:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority encoder; picks the first set
//               mask bit after the pointer, wrapping at NUM_REQ-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import psum_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    localparam int SRC_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [SRC_WIDTH-1:0] i_ptr,
    input  logic [NUM_REQ-1:0]   i_mask,
    output logic [SRC_WIDTH-1:0] o_idx,
    output logic                 o_found
);

    logic [c_MAX_REQ-1:0] w_mask_ext;

    always_comb begin
        w_mask_ext                = '0;
        w_mask_ext[NUM_REQ-1:0]   = i_mask;
        o_idx                     = SRC_WIDTH'(next_rr(int'(i_ptr), w_mask_ext, NUM_REQ));
        o_found                   = |i_mask;
    end

endmodule
`default_nettype wire

// File: rtl/psum_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : psum_drain_arbiter
// Description : Round-robin burst arbiter draining per-column psum FIFOs onto
//               one valid/ready write channel with a source tag.
//               Optional macro PSUM_ARB_WORD_CNT_EN adds word_cnt/burst_trunc.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_drain_arbiter
    import psum_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int BURST_LEN  = 4,
    localparam int SRC_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_empty,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_read_en,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_WIDTH-1:0]          out_src,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef PSUM_ARB_WORD_CNT_EN
   ,output logic [31:0]                   word_cnt,
    output logic                          burst_trunc
`endif
);

    localparam int                c_BEAT_W    = $clog2(BURST_LEN + 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

    logic [c_ST_W-1:0]     r_state;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [SRC_WIDTH-1:0]  r_grant_idx;
    logic [SRC_WIDTH-1:0]  r_rr_ptr;

    logic                  w_can_load;
    logic                  w_head_empty;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_pop;
    logic                  w_last_beat;
    logic                  w_trunc;
    logic [SRC_WIDTH-1:0]  w_win;
    logic                  w_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_ptr   (r_rr_ptr),
        .i_mask  (~req_empty),
        .o_idx   (w_win),
        .o_found (w_any)
    );

    // Head-of-FIFO mux over the granted column.
    always_comb begin
        w_head_empty = 1'b1;
        w_head_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_idx == SRC_WIDTH'(i)) begin
                w_head_empty = req_empty[i];
                w_head_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_can_load  = !out_valid || out_ready;
        w_pop       = (r_state == c_ST_BURST) && w_can_load && !w_head_empty;
        w_trunc     = (r_state == c_ST_BURST) && w_head_empty;
        w_last_beat = (r_beat_cnt == c_LAST_BEAT);
    end

    always_comb begin
        req_read_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pop && (r_grant_idx == SRC_WIDTH'(i))) begin
                req_read_en[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= c_ST_IDLE;
            r_beat_cnt  <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= SRC_WIDTH'(NUM_REQ - 1);
            out_data    <= '0;
            out_src     <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (w_pop) begin
                out_data  <= w_head_data;
                out_src   <= r_grant_idx;
                out_last  <= w_last_beat;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (r_state == c_ST_IDLE) begin
                if (w_any) begin
                    r_grant_idx <= w_win;
                    r_rr_ptr    <= w_win;
                    r_beat_cnt  <= '0;
                    r_state     <= c_ST_BURST;
                end
            end else begin
                if (w_pop) begin
                    r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
                    if (w_last_beat) begin
                        r_state <= c_ST_IDLE;
                    end
                end else if (w_trunc) begin
                    // Column ran dry mid-burst; release the channel early.
                    r_state <= c_ST_IDLE;
                end
            end
        end
    end

`ifdef PSUM_ARB_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            word_cnt    <= '0;
            burst_trunc <= 1'b0;
        end else begin
            burst_trunc <= w_trunc;
            if (out_valid && out_ready) begin
                word_cnt <= word_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_psum_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_drain_arbiter
// Description : Scoreboard bench for psum_drain_arbiter with queue-modelled
//               FIFOs, directed bursts, backpressure, truncation, flush, stress.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_drain_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int BURST_LEN  = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
        logic        last;
    } exp_t;

    logic                          clk;
    logic                          rst;
    logic                          flush;
    logic [NUM_REQ-1:0]            req_empty;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_read_en;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [1:0]                    out_src;
    logic                          out_last;
    logic                          out_valid;
    logic                          out_ready;
`ifdef PSUM_ARB_WORD_CNT_EN
    logic [31:0]                   word_cnt;
    logic                          burst_trunc;
    int                            trunc_seen;
`endif

    psum_drain_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_empty   (req_empty),
        .req_data    (req_data),
        .req_read_en (req_read_en),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef PSUM_ARB_WORD_CNT_EN
       ,.word_cnt    (word_cnt),
        .burst_trunc (burst_trunc)
`endif
    );

    exp_t        exp_q[$];
    logic [15:0] exp_src[NUM_REQ][$];
    logic [15:0] fifo[NUM_REQ][$];
    int          n_checks;
    int          n_errors;
    int          acc_cnt;
    bit          sb_mode;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    function automatic void update_sigs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_empty[i] = (fifo[i].size() == 0);
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = (fifo[i].size() == 0) ? 16'h0 : fifo[i][0];
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [15:0] d);
        fifo[i].push_back(d);
        if (sb_mode) exp_src[i].push_back(d);
        update_sigs();
    endtask

    task automatic expect_w(input logic [15:0] d, input logic [1:0] s, input logic l);
        exp_t e;
        e.data = d;
        e.src  = s;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        int left;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            left = exp_q.size();
            for (int i = 0; i < NUM_REQ; i++) left += fifo[i].size() + exp_src[i].size();
            if (left == 0 && !out_valid) done = 1'b1;
            else cyc();
        end
        if (!done) fail_now({name, " drain timeout"});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        acc_cnt = 0;
    endtask

    // FIFO model: pops take effect just after the edge that samples read_en.
    initial begin
        logic [NUM_REQ-1:0] pm;
        forever begin
            @(negedge clk);
            pm = req_read_en;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pm[i]) begin
                    if (fifo[i].size() == 0) fail_now("pop_of_empty_fifo");
                    else void'(fifo[i].pop_front());
                end
            end
            update_sigs();
        end
    end

    // Monitor: every accepted beat is checked against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && out_valid && out_ready) begin
            acc_cnt++;
            if (!sb_mode) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_src",  32'(out_src),  32'(e.src));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end else begin
                if (exp_src[out_src].size() == 0) fail_now("stress_unexpected_word");
                else check("stress_src_order", 32'(out_data), 32'(exp_src[out_src].pop_front()));
            end
        end
        if (!rst && req_read_en != '0) begin
            check("read_en_onehot0", 32'($onehot0(req_read_en)), 32'd1);
            check("read_en_vs_empty", 32'(req_read_en & req_empty), 32'd0);
        end
    end

`ifdef PSUM_ARB_WORD_CNT_EN
    always @(negedge clk) begin
        if (!rst && burst_trunc) trunc_seen++;
    end
`endif

    initial begin
        int left;
        n_checks  = 0;
        n_errors  = 0;
        acc_cnt   = 0;
        sb_mode   = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        req_empty = '1;
        req_data  = '0;
`ifdef PSUM_ARB_WORD_CNT_EN
        trunc_seen = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_read_en",   32'(req_read_en), 32'd0);

        // Single requester: full burst, bubble, truncated burst.
        for (int k = 0; k < 6; k++) expect_w(16'(16'h10 + k), 2'd2, k == 3);
        cyc();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) push(2, 16'(16'h10 + k));
        @(negedge clk);
        check("t1_idle_no_read", 32'(req_read_en), 32'h0);
        @(negedge clk);
        check("t1_first_pop", 32'(req_read_en), 32'h4);
        @(negedge clk);
        check("t1_valid_latency", 32'(out_valid), 32'd1);
        wait_drain("t1");

        // All four full: grant order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                for (int k = 0; k < BURST_LEN; k++)
                    expect_w(16'(i * 256 + r * 4 + k), 2'(i), k == BURST_LEN - 1);
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 8; k++) push(i, 16'(i * 256 + k));
        wait_drain("t2");

        // Backpressure mid-burst on FIFO 1.
        for (int k = 0; k < 4; k++) expect_w(16'(16'h200 + k), 2'd1, k == 3);
        for (int k = 0; k < 4; k++) push(1, 16'(16'h200 + k));
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 50 && !hit; k++) begin
                @(negedge clk);
                if (out_valid && out_data == 16'h0201) hit = 1'b1;
            end
            if (!hit) fail_now("t3 wait for 0x201 timeout");
        end
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_data",  32'(out_data),    32'h202);
            check("t3_hold_src",   32'(out_src),     32'd1);
            check("t3_hold_valid", 32'(out_valid),   32'd1);
            check("t3_no_read",    32'(req_read_en), 32'h0);
        end
        cyc();
        out_ready = 1'b1;
        wait_drain("t3");

        // Truncation: FIFO 1 short, FIFO 3 exactly one burst.
        do_reset();
        expect_w(16'h300, 2'd1, 1'b0);
        expect_w(16'h301, 2'd1, 1'b0);
        for (int k = 0; k < 4; k++) expect_w(16'(16'h380 + k), 2'd3, k == 3);
`ifdef PSUM_ARB_WORD_CNT_EN
        trunc_seen = 0;
`endif
        push(1, 16'h300);
        push(1, 16'h301);
        for (int k = 0; k < 4; k++) push(3, 16'(16'h380 + k));
        wait_drain("t4");
`ifdef PSUM_ARB_WORD_CNT_EN
        check("t4_burst_trunc_pulses", 32'(trunc_seen), 32'd1);
`endif

        // Flush while a word is stalled in the output register.
        out_ready = 1'b0;
        push(3, 16'h60);
        push(3, 16'h61);
        repeat (4) cyc();
        @(negedge clk);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_data",  32'(out_data),  32'h60);
        cyc();
        push(0, 16'h70);
        push(1, 16'h80);
        expect_w(16'h70, 2'd0, 1'b0);
        expect_w(16'h80, 2'd1, 1'b0);
        expect_w(16'h61, 2'd3, 1'b0);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        acc_cnt = 0;
        @(negedge clk);
        check("t5_flush_valid",   32'(out_valid),   32'd0);
        check("t5_flush_read_en", 32'(req_read_en), 32'h0);
        @(negedge clk);
        check("t5_regrant_lowest", 32'(req_read_en), 32'h1);
        cyc();
        out_ready = 1'b1;
        wait_drain("t5");
`ifdef PSUM_ARB_WORD_CNT_EN
        check("t5_word_cnt", word_cnt, 32'(acc_cnt));
`endif

        // Random stress with per-source ordering.
        sb_mode = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 3) == 0 && fifo[i].size() < 8) push(i, 16'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        out_ready = 1'b1;
        wait_drain("t6");
        left = 0;
        for (int i = 0; i < NUM_REQ; i++) left += exp_src[i].size();
        check("t6_no_loss", 32'(left), 32'd0);
`ifdef PSUM_ARB_WORD_CNT_EN
        check("t6_word_cnt", word_cnt, 32'(acc_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
